// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - circular-buffer FIFO controller in front of a 2**ADDR_W x DATA_W register file
// Optional feature macro: FIFO_EDGE_DETECT_EN (push/pop become rising-edge requests).
module fifo_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              err_ovf,
    output logic              err_udf,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdin,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdout
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, err_ovf_q, err_udf_q;
    logic              push_req, pop_req, push_acc, pop_acc;

`ifdef FIFO_EDGE_DETECT_EN
    logic push_prev_q, pop_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_prev_q <= 1'b0;
            pop_prev_q  <= 1'b0;
        end else begin
            push_prev_q <= push;
            pop_prev_q  <= pop;
        end
    end

    assign push_req = push & ~push_prev_q;
    assign pop_req  = pop & ~pop_prev_q;
`else
    assign push_req = push;
    assign pop_req  = pop;
`endif

    // Flags derive from occupancy; pointers alone cannot tell full from empty.
    assign full     = (count_q == DEPTH);
    assign empty    = (count_q == '0);
    assign pop_acc  = pop_req & ~empty;
    assign push_acc = push_req & (~full | pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push_acc);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop_acc);
        dout_d   = pop_acc ? rf_rdout : dout_q;
        count_d  = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_udf_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= pop_acc;
            err_ovf_q    <= push_req & ~push_acc;
            err_udf_q    <= pop_req & ~pop_acc;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign err_ovf    = err_ovf_q;
    assign err_udf    = err_udf_q;

    // When full, rf_raddr == rf_waddr: the RAM read is combinational, so the old word is captured.
    assign rf_waddr = wr_ptr_q;
    assign rf_wdin  = din;
    assign rf_wena  = push_acc;
    assign rf_raddr = rd_ptr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - randomized self-checking bench for fifo_ctrl against a queue model
module tb_fifo_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          push, pop;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid, full, empty, err_ovf, err_udf;
    logic [AW:0]   count;
    logic [AW-1:0] rf_waddr, rf_raddr;
    logic [DW-1:0] rf_wdin, rf_rdout;
    logic          rf_wena;

    logic [DW-1:0] ram [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_dout;
    logic          exp_dv, exp_ovf, exp_udf;
    logic          m_prev_push, m_prev_pop;

    fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .count(count), .err_ovf(err_ovf), .err_udf(err_udf),
        .rf_waddr(rf_waddr), .rf_wdin(rf_wdin), .rf_wena(rf_wena),
        .rf_raddr(rf_raddr), .rf_rdout(rf_rdout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_wena) ram[rf_waddr] <= rf_wdin;
    assign rf_rdout = ram[rf_raddr];

    task automatic model_clear();
        mq.delete();
        exp_dout = '0; exp_dv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        m_prev_push = 1'b0; m_prev_pop = 1'b0;
    endtask

    // Drives one cycle at the falling edge, predicts the outcome, returns 1 ns after the rising edge.
    task automatic drive_raw(input logic p, input logic [DW-1:0] d, input logic o);
        logic rp, ro, pop_ok, push_ok;
        @(negedge clk);
        push = p; din = d; pop = o;
`ifdef FIFO_EDGE_DETECT_EN
        rp = p & ~m_prev_push;
        ro = o & ~m_prev_pop;
`else
        rp = p;
        ro = o;
`endif
        m_prev_push = p;
        m_prev_pop  = o;
        pop_ok  = ro && (mq.size() > 0);
        push_ok = rp && ((mq.size() < DEPTH) || pop_ok);
        exp_dv  = pop_ok;
        exp_ovf = rp && !push_ok;
        exp_udf = ro && !pop_ok;
        if (pop_ok)  exp_dout = mq.pop_front();
        if (push_ok) mq.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [DW-1:0] d, input logic o);
`ifdef FIFO_EDGE_DETECT_EN
        if ((p && m_prev_push) || (o && m_prev_pop)) drive_raw(1'b0, '0, 1'b0);
`endif
        drive_raw(p, d, o);
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
        n_checks++; if ({dout_valid, err_ovf, err_udf} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {dout_valid, err_ovf, err_udf}); end
        n_checks++; if ({rf_waddr, rf_raddr} !== 12'h0) begin n_fail++; $display("FAIL reset_ptrs: got w=%0d r=%0d expected 0", rf_waddr, rf_raddr); end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [3];
        vals = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) drive(1'b1, vals[i], 1'b0);
        n_checks++; if (count !== 7'd3 || empty !== 1'b0) begin n_fail++; $display("FAIL fill3_count: got %0d/%b expected 3/0", count, empty); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ram[i] !== vals[i]) begin n_fail++; $display("FAIL fill3_ram%0d: got %h expected %h", i, ram[i], vals[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++; if (dout_valid !== 1'b1 || dout !== vals[i]) begin n_fail++; $display("FAIL drain3_word%0d: got %h valid %b expected %h valid 1", i, dout, dout_valid, vals[i]); end
        end
        n_checks++; if (count !== 7'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain3_empty: got %0d/%b expected 0/1", count, empty); end
        drive(1'b0, '0, 1'b0);
        n_checks++; if (dout_valid !== 1'b0 || dout !== 32'h33) begin n_fail++; $display("FAIL drain3_hold: got %h valid %b expected 33 valid 0", dout, dout_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 1'b0);
        n_checks++; if (full !== 1'b1 || count !== 7'd64) begin n_fail++; $display("FAIL ovf_full: got %0d/%b expected 64/1", count, full); end
        drive(1'b1, 32'hDEAD, 1'b0);
        n_checks++; if (err_ovf !== 1'b1 || count !== 7'd64) begin n_fail++; $display("FAIL ovf_pulse: got err %b count %0d expected 1/64", err_ovf, count); end
        drive(1'b0, '0, 1'b0);
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b expected 0", err_ovf); end
    endtask

    task automatic test_full_push_pop();
        drive(1'b1, 32'hAA, 1'b1);
        n_checks++; if (dout_valid !== 1'b1 || dout !== 32'h0 || count !== 7'd64) begin n_fail++; $display("FAIL fullpp_first: got %h/%b/%0d expected 0/1/64", dout, dout_valid, count); end
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++; if (dout !== 32'(i)) begin n_fail++; $display("FAIL fullpp_word%0d: got %h expected %h", i, dout, 32'(i)); end
        end
        drive(1'b0, '0, 1'b1);
        n_checks++; if (dout !== 32'hAA || count !== 7'd0) begin n_fail++; $display("FAIL fullpp_last: got %h count %0d expected aa/0", dout, count); end
    endtask

    task automatic test_underflow();
        drive(1'b0, '0, 1'b1);
        n_checks++; if (err_udf !== 1'b1 || dout_valid !== 1'b0 || dout !== 32'hAA) begin n_fail++; $display("FAIL udf_pop: got err %b valid %b dout %h expected 1/0/aa", err_udf, dout_valid, dout); end
        drive(1'b1, 32'h55, 1'b1);
        n_checks++; if (err_udf !== 1'b1 || count !== 7'd1 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL udf_pushpop: got err %b count %0d valid %b expected 1/1/0", err_udf, count, dout_valid); end
        drive(1'b0, '0, 1'b1);
        n_checks++; if (dout !== 32'h55 || err_udf !== 1'b0 || count !== 7'd0) begin n_fail++; $display("FAIL udf_recover: got %h err %b count %0d expected 55/0/0", dout, err_udf, count); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 540; i++) begin
            logic p, o;
            if (i < 140) begin
                p = (i % 2 == 0);
                o = (i % 2 == 1);
            end else if (i < 340) begin
                p = ($urandom_range(99) < 80);
                o = ($urandom_range(99) < 25);
            end else begin
                p = ($urandom_range(99) < 25);
                o = ($urandom_range(99) < 80);
            end
            drive(p, $urandom, o);
            n_checks++;
            if (count !== 7'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)
                || dout_valid !== exp_dv || dout !== exp_dout || err_ovf !== exp_ovf || err_udf !== exp_udf) begin
                n_fail++; errs++;
                if (errs <= 5)
                    $display("FAIL random_step%0d: got cnt %0d dv %b dout %h ovf %b udf %b expected cnt %0d dv %b dout %h ovf %b udf %b",
                             i, count, dout_valid, dout, err_ovf, err_udf, mq.size(), exp_dv, exp_dout, exp_ovf, exp_udf);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hC0 + i, 1'b0);
        @(negedge clk);
        push = 1'b1; din = 32'hBAD; pop = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got %0d/%b/%b expected 0/1/0", count, empty, full); end
        n_checks++; if (dout !== 32'h0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dout: got %h/%b expected 0/0", dout, dout_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        model_clear();
        drive(1'b1, 32'h99, 1'b0);
        drive(1'b0, '0, 1'b1);
        n_checks++; if (dout !== 32'h99 || count !== 7'd0) begin n_fail++; $display("FAIL midrst_recover: got %h count %0d expected 99/0", dout, count); end
    endtask

`ifdef FIFO_EDGE_DETECT_EN
    task automatic test_edge_detect();
        int pulses = 0;
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) drive_raw(1'b1, 32'h77, 1'b0);
        n_checks++; if (count !== 7'd1) begin n_fail++; $display("FAIL edge_push_held: got %0d expected 1", count); end
        drive_raw(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_raw(1'b0, '0, 1'b1);
            if (dout_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 1 || count !== 7'd0 || dout !== 32'h77) begin n_fail++; $display("FAIL edge_pop_held: got %0d pulses count %0d dout %h expected 1/0/77", pulses, count, dout); end
        drive_raw(1'b0, '0, 1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_random();
        test_reset_mid_burst();
`ifdef FIFO_EDGE_DETECT_EN
        test_edge_detect();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
